// File: rtl/ex_stage.sv
// Execute stage: logic/shift/arith/compare, HI/LO ownership, and a 32-step
// iterative multiplier that stalls upstream while it runs.
`ifndef EX_STAGE_DEFINES
`define EX_STAGE_DEFINES
`define WORD_BUS        31:0
`define REG_ADDR_BUS    4:0
`define EX_OP_BUS       5:0
`define EX_HIGH_SPECIAL 2'b00
`define EX_HIGH_LOGIC   2'b01
`define EX_HIGH_ARITH   2'b10
`define EX_LOW_NOP      4'h0
`define EX_LOW_AND      4'h0
`define EX_LOW_OR       4'h1
`define EX_LOW_XOR      4'h2
`define EX_LOW_NOR      4'h3
`define EX_LOW_SHLEFT   4'h4
`define EX_LOW_SHRLOG   4'h5
`define EX_LOW_SHRARI   4'h6
`define EX_LOW_FROMHI   4'h7
`define EX_LOW_FROMLO   4'h8
`define EX_LOW_TOHI     4'h9
`define EX_LOW_TOLO     4'hA
`define EX_LOW_ADD      4'h0
`define EX_LOW_ADDU     4'h1
`define EX_LOW_SUB      4'h2
`define EX_LOW_SUBU     4'h3
`define EX_LOW_MULT     4'h4
`define EX_LOW_MULTU    4'h5
`define EX_LOW_SLT      4'h6
`define EX_LOW_SLTU     4'h7
`endif

module ex_stage (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [`EX_OP_BUS]    i_exop,
  input  logic [`WORD_BUS]     i_srcLeft,
  input  logic [`WORD_BUS]     i_srcRight,
  input  logic [`REG_ADDR_BUS] i_dest,
  output logic                 o_stall,
  output logic                 o_wen,
  output logic [`REG_ADDR_BUS] o_dest,
  output logic [`WORD_BUS]     o_result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state;
  logic [4:0]  count;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic        neg;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [1:0]  op_high;
  logic [3:0]  op_low;
  logic        is_mul;
  logic        is_signed_mul;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] result;
  logic        writes_gpr;
  logic        ovf;
  logic [63:0] product;
  logic [31:0] mag_left;
  logic [31:0] mag_right;

  assign op_high       = i_exop[5:4];
  assign op_low        = i_exop[3:0];
  assign is_mul        = (op_high == `EX_HIGH_ARITH) &&
                         ((op_low == `EX_LOW_MULT) || (op_low == `EX_LOW_MULTU));
  assign is_signed_mul = (op_low == `EX_LOW_MULT);
  assign o_stall       = ((state == IDLE) && i_valid && is_mul) || (state == BUSY);
  assign sum           = i_srcLeft + i_srcRight;
  assign diff          = i_srcLeft - i_srcRight;
  assign product       = neg ? (~acc + 64'd1) : acc;
  assign mag_left      = (is_signed_mul && i_srcLeft[31])  ? (~i_srcLeft + 32'd1)  : i_srcLeft;
  assign mag_right     = (is_signed_mul && i_srcRight[31]) ? (~i_srcRight + 32'd1) : i_srcRight;

  always_comb begin
    result     = '0;
    writes_gpr = 1'b0;
    ovf        = 1'b0;
    if (op_high == `EX_HIGH_LOGIC) begin
      writes_gpr = 1'b1;
      case (op_low)
        `EX_LOW_AND:    result = i_srcLeft & i_srcRight;
        `EX_LOW_OR:     result = i_srcLeft | i_srcRight;
        `EX_LOW_XOR:    result = i_srcLeft ^ i_srcRight;
        `EX_LOW_NOR:    result = ~(i_srcLeft | i_srcRight);
        `EX_LOW_SHLEFT: result = i_srcRight << i_srcLeft[4:0];
        `EX_LOW_SHRLOG: result = i_srcRight >> i_srcLeft[4:0];
        `EX_LOW_SHRARI: result = $unsigned($signed(i_srcRight) >>> i_srcLeft[4:0]);
        `EX_LOW_FROMHI: result = hi;
        `EX_LOW_FROMLO: result = lo;
        default:        writes_gpr = 1'b0;
      endcase
    end else if (op_high == `EX_HIGH_ARITH) begin
      writes_gpr = 1'b1;
      case (op_low)
        `EX_LOW_ADD: begin
          result = sum;
          ovf    = (i_srcLeft[31] == i_srcRight[31]) && (sum[31] != i_srcLeft[31]);
        end
        `EX_LOW_ADDU: result = sum;
        `EX_LOW_SUB: begin
          result = diff;
          ovf    = (i_srcLeft[31] != i_srcRight[31]) && (diff[31] != i_srcLeft[31]);
        end
        `EX_LOW_SUBU: result = diff;
        `EX_LOW_SLT:  result = {31'b0, $signed(i_srcLeft) < $signed(i_srcRight)};
        `EX_LOW_SLTU: result = {31'b0, i_srcLeft < i_srcRight};
        default:      writes_gpr = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && is_mul) begin
            mcand  <= {32'b0, mag_left};
            mplier <= mag_right;
            neg    <= is_signed_mul && (i_srcLeft[31] ^ i_srcRight[31]);
            acc    <= '0;
            count  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The multiplier result lands on the DONE edge; TOHI/TOLO can never coincide
  // because the multiply still occupies the ID/EX latch then.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE) begin
      hi <= product[63:32];
      lo <= product[31:0];
    end else if (!o_stall && i_valid && (op_high == `EX_HIGH_LOGIC)) begin
      if (op_low == `EX_LOW_TOHI) hi <= i_srcLeft;
      if (op_low == `EX_LOW_TOLO) lo <= i_srcLeft;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wen    <= 1'b0;
      o_dest   <= '0;
      o_result <= '0;
    end else if (o_stall) begin
      o_wen    <= 1'b0;
      o_dest   <= '0;
      o_result <= '0;
    end else begin
      o_wen    <= i_valid && writes_gpr && (i_dest != 5'd0) && !ovf;
      o_dest   <= (i_valid && writes_gpr && (i_dest != 5'd0) && !ovf) ? i_dest : 5'd0;
      o_result <= result;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases from the plan plus randomized ops,
// checked against an arithmetic reference model of the execute stage.
module tb_ex_stage;

  localparam logic [5:0] OP_NOP    = 6'b00_0000;
  localparam logic [5:0] OP_AND    = 6'b01_0000;
  localparam logic [5:0] OP_OR     = 6'b01_0001;
  localparam logic [5:0] OP_XOR    = 6'b01_0010;
  localparam logic [5:0] OP_NOR    = 6'b01_0011;
  localparam logic [5:0] OP_SLL    = 6'b01_0100;
  localparam logic [5:0] OP_SRL    = 6'b01_0101;
  localparam logic [5:0] OP_SRA    = 6'b01_0110;
  localparam logic [5:0] OP_MFHI   = 6'b01_0111;
  localparam logic [5:0] OP_MFLO   = 6'b01_1000;
  localparam logic [5:0] OP_MTHI   = 6'b01_1001;
  localparam logic [5:0] OP_MTLO   = 6'b01_1010;
  localparam logic [5:0] OP_ADD    = 6'b10_0000;
  localparam logic [5:0] OP_ADDU   = 6'b10_0001;
  localparam logic [5:0] OP_SUB    = 6'b10_0010;
  localparam logic [5:0] OP_SUBU   = 6'b10_0011;
  localparam logic [5:0] OP_MULT   = 6'b10_0100;
  localparam logic [5:0] OP_MULTU  = 6'b10_0101;
  localparam logic [5:0] OP_SLT    = 6'b10_0110;
  localparam logic [5:0] OP_SLTU   = 6'b10_0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [5:0]  exop;
  logic [31:0] src_left;
  logic [31:0] src_right;
  logic [4:0]  dest;
  logic        stall;
  logic        wen;
  logic [4:0]  dest_q;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  ex_stage dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .i_exop    (exop),
    .i_srcLeft (src_left),
    .i_srcRight(src_right),
    .i_dest    (dest),
    .o_stall   (stall),
    .o_wen     (wen),
    .o_dest    (dest_q),
    .o_result  (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what a single-cycle op retires, from plain arithmetic.
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic v,
                       output logic e_wen, output logic [4:0] e_dest, output logic [31:0] e_res);
    longint sa, sb, s;
    logic   gpr;
    gpr   = 1'b1;
    e_res = '0;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    case (op)
      OP_AND:  e_res = a & b;
      OP_OR:   e_res = a | b;
      OP_XOR:  e_res = a ^ b;
      OP_NOR:  e_res = ~(a | b);
      OP_SLL:  e_res = 32'((64'(b) * (64'd1 << a[4:0])));
      OP_SRL:  e_res = 32'(64'(b) / (64'd1 << a[4:0]));
      OP_SRA:  e_res = 32'(sb >>> a[4:0]);
      OP_MFHI: e_res = m_hi;
      OP_MFLO: e_res = m_lo;
      OP_ADD: begin
        s = sa + sb; e_res = 32'(s);
        if (s > 64'sd2147483647 || s < -64'sd2147483648) gpr = 1'b0;
      end
      OP_ADDU: e_res = 32'(sa + sb);
      OP_SUB: begin
        s = sa - sb; e_res = 32'(s);
        if (s > 64'sd2147483647 || s < -64'sd2147483648) gpr = 1'b0;
      end
      OP_SUBU: e_res = 32'(sa - sb);
      OP_SLT:  e_res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: e_res = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
      default: gpr = 1'b0;
    endcase
    if (v && op == OP_MTHI) m_hi = a;
    if (v && op == OP_MTLO) m_lo = a;
    e_wen  = v && gpr && (d != 5'd0);
    e_dest = e_wen ? d : 5'd0;
  endtask

  // Called at posedge+1; presents one single-cycle op and checks its retirement.
  task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic v);
    logic e_wen; logic [4:0] e_dest; logic [31:0] e_res;
    valid = v; exop = op; src_left = a; src_right = b; dest = d;
    #1;
    check({tag, "_stall"}, 32'(stall), 32'd0);
    model(op, a, b, d, v, e_wen, e_dest, e_res);
    @(posedge clk); #1;
    check({tag, "_wen"}, 32'(wen), 32'(e_wen));
    check({tag, "_dest"}, 32'(dest_q), 32'(e_dest));
    if (e_wen) check({tag, "_res"}, result, e_res);
  endtask

  task automatic do_mul(input string tag, input logic signed_op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    logic [63:0] p;
    valid = 1'b1; exop = signed_op ? OP_MULT : OP_MULTU;
    src_left = a; src_right = b; dest = 5'd9;
    #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd33);
    @(posedge clk); #1;
    check({tag, "_wen"}, 32'(wen), 32'd0);
    if (signed_op) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else           p = {32'b0, a} * {32'b0, b};
    m_hi = p[63:32];
    m_lo = p[31:0];
  endtask

  logic [5:0] rand_ops [18] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                                OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_ADD, OP_ADDU,
                                OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_NOP};

  initial begin
    rst_n = 1'b0; valid = 1'b0; exop = OP_NOP;
    src_left = '0; src_right = '0; dest = '0;
    #12;
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_dest", 32'(dest_q), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b1);
    check("add_ovf_const", 32'(wen), 32'd0);
    do_op("addu", OP_ADDU, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b1);
    check("addu_const", result, 32'h80000000);
    do_op("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 5'd6, 1'b1);
    do_op("sra", OP_SRA, 32'd4, 32'hF0000000, 5'd7, 1'b1);
    check("sra_const", result, 32'hFF000000);
    do_op("srl", OP_SRL, 32'd4, 32'hF0000000, 5'd7, 1'b1);
    check("srl_const", result, 32'h0F000000);
    do_op("sll", OP_SLL, 32'h24, 32'd1, 5'd8, 1'b1);
    check("sll_const", result, 32'h10);
    do_op("slt", OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd3, 1'b1);
    check("slt_const", result, 32'd1);
    do_op("sltu", OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd3, 1'b1);
    check("sltu_const", result, 32'd0);
    do_op("dest0", OP_ADDU, 32'd3, 32'd4, 5'd0, 1'b1);
    do_op("invalid", OP_OR, 32'd3, 32'd4, 5'd2, 1'b0);

    do_mul("mult_neg", 1'b1, 32'hFFFFFFFD, 32'd7);
    do_op("mfhi1", OP_MFHI, 32'd0, 32'd0, 5'd10, 1'b1);
    check("mfhi1_const", result, 32'hFFFFFFFF);
    do_op("mflo1", OP_MFLO, 32'd0, 32'd0, 5'd11, 1'b1);
    check("mflo1_const", result, 32'hFFFFFFEB);

    do_mul("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("mfhi2", OP_MFHI, 32'd0, 32'd0, 5'd10, 1'b1);
    check("mfhi2_const", result, 32'hFFFFFFFE);
    do_op("mflo2", OP_MFLO, 32'd0, 32'd0, 5'd11, 1'b1);
    check("mflo2_const", result, 32'h00000001);

    do_op("mthi", OP_MTHI, 32'h12345678, 32'd0, 5'd4, 1'b1);
    do_op("mfhi3", OP_MFHI, 32'd0, 32'd0, 5'd12, 1'b1);
    do_mul("mult_b2b_a", 1'b1, 32'h80000000, 32'h80000000);
    do_mul("mult_b2b_b", 1'b1, 32'h12345, 32'hFFFF0001);
    do_op("mflo3", OP_MFLO, 32'd0, 32'd0, 5'd13, 1'b1);
    do_op("mfhi4", OP_MFHI, 32'd0, 32'd0, 5'd13, 1'b1);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'h7FFFFFFF ^ {31{a[0]}}};
      do_op("rand", rand_ops[$urandom_range(0, 17)], a, b, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) != 0));
    end

    for (int i = 0; i < 3; i++) begin
      logic s;
      s = 1'($urandom_range(0, 1));
      do_mul("rand_mul", s, $urandom, $urandom);
      do_op("rand_mfhi", OP_MFHI, 32'd0, 32'd0, 5'd14, 1'b1);
      do_op("rand_mflo", OP_MFLO, 32'd0, 32'd0, 5'd15, 1'b1);
    end

    // Abort a multiply at BUSY count 10 after HI/LO have been made nonzero.
    do_op("mtlo_pre", OP_MTLO, 32'hA5A5A5A5, 32'd0, 5'd1, 1'b1);
    valid = 1'b1; exop = OP_MULT; src_left = 32'd5; src_right = 32'd6; dest = 5'd2;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    check("mid_stall", 32'(stall), 32'd1);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_wen", 32'(wen), 32'd0);
    check("abort_dest", 32'(dest_q), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("abort_mfhi", OP_MFHI, 32'd0, 32'd0, 5'd16, 1'b1);
    check("abort_hi_const", result, 32'd0);
    do_op("abort_mflo", OP_MFLO, 32'd0, 32'd0, 5'd17, 1'b1);
    check("abort_lo_const", result, 32'd0);
    do_mul("post_rst_mult", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFB);
    do_op("post_mflo", OP_MFLO, 32'd0, 32'd0, 5'd18, 1'b1);
    check("post_mflo_const", result, 32'd35);
    do_op("post_mfhi", OP_MFHI, 32'd0, 32'd0, 5'd18, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
